register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_pkg.sv | 17 +
 rtl/regbank_bypass.sv | 31 +++
 rtl/register_bank.sv | 155 +++++++++++++++
 tb/tb_register_bank.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// -----------------------------------------------------------------------------
// register_bank_pkg
// Shared MIPS datapath constants used by the register bank and its helpers.
//   DATA_W_DEF : default register width in bits
//   ADDR_W_DEF : default register address width (depth = 2**ADDR_W)
//   REG_ZERO   : index of the hard-wired zero register
//   CNT_W      : width of the committed-write counter
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package register_bank_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned CNT_W      = 16;

endpackage : register_bank_pkg

// File: rtl/regbank_bypass.sv
// -----------------------------------------------------------------------------
// regbank_bypass
// Per-read-port write-through bypass. When a write is committing this cycle to
// the address being read, the port returns the incoming write data instead of
// the (not yet updated) stored value.
//   wr_commit_i  : a write will commit on the next rising edge
//   wr_addr_i    : address of that write
//   wr_data_i    : data of that write
//   rd_addr_i    : address read by this port
//   store_data_i : stored value at rd_addr_i (already zero for register 0)
//   rd_data_o    : value presented on the read port
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module regbank_bypass #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              wr_commit_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  // wr_commit_i already excludes register 0, so the zero register can never be
  // bypassed to a non-zero value here.
  assign rd_data_o = (wr_commit_i && (rd_addr_i == wr_addr_i)) ? wr_data_i
                                                               : store_data_i;

endmodule : regbank_bypass

// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
// 2**ADDR_W x DATA_W MIPS register file with two combinational read ports
// (with write-through bypass), one write port, a registered debug read port
// and a wrapping counter of committed writes. Register 0 always reads 0.
//   clk, rst_n           : clock, asynchronous active-low reset
//   reg_write            : write enable
//   write_addr/data      : write port (writes to register 0 are discarded)
//   read_addr1/data1     : rs read port, zero-cycle latency
//   read_addr2/data2     : rt read port, zero-cycle latency
//   dbg_addr/dbg_data    : debug read, one cycle latency, post-write value
//   write_count          : number of committed writes, wraps at 16 bits
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module register_bank
  import register_bank_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  write_count
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  // ---------------------------------------------------------------------------
  // Write arming. armed_q is cleared by reset and sets on the first rising edge
  // after release, so a write presented on the edge at which reset deasserts
  // is dropped; the first write commits on the following edge. It also blocks
  // the read bypass while reset is active.
  // ---------------------------------------------------------------------------
  logic armed_q;

  // NOTE: sequential state is updated with non-blocking (<=) assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  logic wr_commit;
  assign wr_commit = armed_q && reg_write && (write_addr != ZERO_ADDR);

  // ---------------------------------------------------------------------------
  // Storage: a flop array so the whole bank clears asynchronously.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [DEPTH];

  // NOTE: this array is deliberately reset. A reset on every entry rules out a
  // RAM macro, which is intended: the bank must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit) begin
      regs_q[write_addr] <= write_data;
    end
  end

  // Stored values seen by each port; register 0 is forced to zero here so the
  // hard-wired zero does not depend on entry 0 never being written.
  logic [DATA_W-1:0] store_rd1;
  logic [DATA_W-1:0] store_rd2;
  logic [DATA_W-1:0] store_dbg;

  assign store_rd1 = (read_addr1 == ZERO_ADDR) ? '0 : regs_q[read_addr1];
  assign store_rd2 = (read_addr2 == ZERO_ADDR) ? '0 : regs_q[read_addr2];
  assign store_dbg = (dbg_addr   == ZERO_ADDR) ? '0 : regs_q[dbg_addr];

  // ---------------------------------------------------------------------------
  // Read ports with write-through bypass.
  // ---------------------------------------------------------------------------
  regbank_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass_rs (
    .wr_commit_i  (wr_commit),
    .wr_addr_i    (write_addr),
    .wr_data_i    (write_data),
    .rd_addr_i    (read_addr1),
    .store_data_i (store_rd1),
    .rd_data_o    (read_data1)
  );

  regbank_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass_rt (
    .wr_commit_i  (wr_commit),
    .wr_addr_i    (write_addr),
    .wr_data_i    (write_data),
    .rd_addr_i    (read_addr2),
    .store_data_i (store_rd2),
    .rd_data_o    (read_data2)
  );

  // ---------------------------------------------------------------------------
  // Debug read and write counter.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] dbg_data_q;
  logic [DATA_W-1:0] dbg_data_d;
  logic [CNT_W-1:0]  write_count_q;
  logic [CNT_W-1:0]  write_count_d;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    dbg_data_d    = store_dbg;
    write_count_d = write_count_q;
    // A same-edge write to the observed register shows its new value.
    if (wr_commit && (dbg_addr == write_addr)) begin
      dbg_data_d = write_data;
    end
    // Natural 16-bit overflow gives the 0xFFFF -> 0x0000 wrap.
    if (wr_commit) begin
      write_count_d = write_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_data_q    <= '0;
      write_count_q <= '0;
    end else begin
      dbg_data_q    <= dbg_data_d;
      write_count_q <= write_count_d;
    end
  end

  assign dbg_data    = dbg_data_q;
  assign write_count = write_count_q;

  // An unknown write address can never satisfy the commit decode, so storage
  // is untouched; flag it so the source of the X gets fixed.
  a_write_addr_known : assert property (
    @(posedge clk) disable iff (!rst_n) reg_write |-> !$isunknown(write_addr)
  );

endmodule : register_bank

// File: tb/tb_register_bank.sv
// -----------------------------------------------------------------------------
// tb_register_bank
// Directed self-checking bench for register_bank. Inputs change 1 ns after a
// rising edge; outputs are sampled a further 1 ns later, away from the edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [15:0] write_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  register_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_write   (reg_write),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_addr1  (read_addr1),
    .read_addr2  (read_addr2),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .write_count (write_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One write cycle: present the write, take the edge, drop reg_write.
  task automatic write_cycle(input logic [4:0] a, input logic [31:0] d);
    reg_write  = 1'b1;
    write_addr = a;
    write_data = d;
    @(posedge clk);
    #1;
    reg_write  = 1'b0;
  endtask

  task automatic read_both(input logic [4:0] a1, input logic [4:0] a2);
    read_addr1 = a1;
    read_addr2 = a2;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    int unsigned burst;

    rst_n      = 1'b0;
    reg_write  = 1'b0;
    write_addr = '0;
    write_data = '0;
    read_addr1 = '0;
    read_addr2 = '0;
    dbg_addr   = '0;
    last_addr  = '0;
    last_data  = '0;

    // ---------------- reset state, writes ignored during reset ----------------
    #12;
    reg_write  = 1'b1;
    write_addr = 5'd4;
    write_data = 32'h0000_0044;
    read_both(5'd4, 5'd4);
    check("rst_bypass_rd1", read_data1, 32'h0);
    check("rst_bypass_rd2", read_data2, 32'h0);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    #1;
    check("rst_write_ignored", read_data1, 32'h0);
    check("rst_count", 32'(write_count), 32'h0);
    check("rst_dbg", dbg_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);           // arming edge after release
    #1;

    for (int i = 0; i < 32; i++) begin
      read_both(5'(i), 5'(31 - i));
      check($sformatf("rst_rd1[%0d]", i), read_data1, 32'h0);
      check($sformatf("rst_rd2[%0d]", 31 - i), read_data2, 32'h0);
    end
    check("rst_count_after", 32'(write_count), 32'h0);

    // ---------------- reset mid-sequence, write on the deassert edge ----------
    write_cycle(5'd5, 32'h0000_0007);
    read_both(5'd5, 5'd5);
    check("r5_before_rst", read_data1, 32'h0000_0007);
    check("cnt_before_rst", 32'(write_count), 32'h1);
    reg_write  = 1'b1;        // in-flight write to r6, must be discarded
    write_addr = 5'd6;
    write_data = 32'h0000_0066;
    #2;
    rst_n = 1'b0;             // between edges
    read_both(5'd5, 5'd6);
    check("r5_async_clear", read_data1, 32'h0);
    check("r6_inflight_rd", read_data2, 32'h0);
    check("cnt_async_clear", 32'(write_count), 32'h0);
    check("dbg_async_clear", dbg_data, 32'h0);
    write_addr = 5'd5;        // this write is held across the deassert edge
    write_data = 32'h0000_0009;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);           // deassert edge: write must not commit
    #1;
    reg_write = 1'b0;
    read_both(5'd5, 5'd6);
    check("r5_deassert_edge", read_data1, 32'h0);
    check("r6_inflight_lost", read_data2, 32'h0);
    check("cnt_deassert_edge", 32'(write_count), 32'h0);
    write_cycle(5'd5, 32'h0000_0009);
    read_both(5'd5, 5'd5);
    check("r5_first_write", read_data1, 32'h0000_0009);
    check("cnt_first_write", 32'(write_count), 32'h1);

    // ---------------- basic write/read ----------------
    write_cycle(5'd8, 32'hDEAD_BEEF);
    read_both(5'd8, 5'd8);
    check("r8_rd1", read_data1, 32'hDEAD_BEEF);
    check("r8_rd2", read_data2, 32'hDEAD_BEEF);
    check("cnt_r8", 32'(write_count), 32'h2);

    // ---------------- write to r0 discarded, no bypass ----------------
    reg_write  = 1'b1;
    write_addr = 5'd0;
    write_data = 32'h1234_5678;
    read_both(5'd0, 5'd0);
    check("r0_bypass_rd1", read_data1, 32'h0);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    read_both(5'd0, 5'd0);
    check("r0_rd1", read_data1, 32'h0);
    check("r0_rd2", read_data2, 32'h0);
    check("cnt_r0", 32'(write_count), 32'h2);

    // ---------------- same-cycle bypass and debug read ----------------
    reg_write  = 1'b1;
    write_addr = 5'd31;
    write_data = 32'hA5A5_A5A5;
    dbg_addr   = 5'd31;
    read_both(5'd31, 5'd8);
    check("r31_bypass_rd1", read_data1, 32'hA5A5_A5A5);
    check("r8_no_bypass_rd2", read_data2, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    #1;
    check("dbg_r31_same_edge", dbg_data, 32'hA5A5_A5A5);
    check("cnt_r31", 32'(write_count), 32'h3);
    dbg_addr = 5'd8;
    @(posedge clk);
    #1;
    check("dbg_r8", dbg_data, 32'hDEAD_BEEF);
    dbg_addr = 5'd0;
    @(posedge clk);
    #1;
    check("dbg_r0", dbg_data, 32'h0);

    // ---------------- assorted patterns ----------------
    write_cycle(5'd1,  32'h0000_0001);
    write_cycle(5'd2,  32'hFFFF_FFFF);
    write_cycle(5'd30, 32'h8000_0001);
    read_both(5'd1, 5'd2);
    check("r1", read_data1, 32'h0000_0001);
    check("r2", read_data2, 32'hFFFF_FFFF);
    read_both(5'd30, 5'd31);
    check("r30", read_data1, 32'h8000_0001);
    check("r31_kept", read_data2, 32'hA5A5_A5A5);
    check("cnt_patterns", 32'(write_count), 32'h6);

    // ---------------- counter wrap ----------------
    burst     = 32'hFFFF - 32'd6;
    reg_write = 1'b1;
    for (int unsigned i = 0; i < burst; i++) begin
      last_addr  = 5'((i % 31) + 1);
      last_data  = 32'h1000_0000 + i;
      write_addr = last_addr;
      write_data = last_data;
      @(posedge clk);
      #1;
    end
    reg_write = 1'b0;
    read_both(last_addr, last_addr);
    check("burst_last_data", read_data1, last_data);
    check("cnt_ffff", 32'(write_count), 32'h0000_FFFF);
    write_cycle(5'd3, 32'hCAFE_F00D);
    read_both(5'd3, 5'd0);
    check("cnt_wrap", 32'(write_count), 32'h0);
    check("r3_after_wrap", read_data1, 32'hCAFE_F00D);
    check("r0_after_wrap", read_data2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_register_bank
